// File: rtl/vc_input_port.sv
// Router input port: one FIFO + route/VC-alloc/switch FSM per virtual channel,
// with round-robin arbitration for the shared route, VC-alloc and switch requests.
module vc_lane #(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4,
  parameter int VCW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [FLIT_W-1:0] wr_data,
  input  logic              sw_pop,
  input  logic              route_start,
  input  logic              route_ok,
  input  logic [2:0]        route_dir,
  input  logic              vca_ok,
  input  logic [VCW-1:0]    grant_ovc,
  output logic [FLIT_W-1:0] front,
  output logic              full,
  output logic              pop,
  output logic              route_elig,
  output logic              vca_wait,
  output logic              active_rdy,
  output logic [2:0]        dir,
  output logic [VCW-1:0]    ovc
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, ROUTE = 2'd1, VCA = 2'd2, ACTIVE = 2'd3;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic [1:0]        state;
  logic              empty, discard;

  assign empty      = (count == '0);
  assign full       = (count == (PW+1)'(DEPTH));
  assign front      = mem[rd_ptr];
  // Body/tail reaching the front of an idle VC belongs to no packet: drop it.
  assign discard    = (state == IDLE) && !empty && !front[FLIT_W-2];
  assign pop        = discard || sw_pop;
  assign route_elig = (state == IDLE) && !empty && front[FLIT_W-2];
  assign vca_wait   = (state == VCA);
  assign active_rdy = (state == ACTIVE) && !empty;

  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
      dir    <= '0;
      ovc    <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !pop)      count <= count + 1'b1;
      else if (!wr && pop) count <= count - 1'b1;
      case (state)
        IDLE:   if (route_start) state <= ROUTE;
        ROUTE:  if (route_ok) begin state <= VCA; dir <= route_dir; end
        VCA:    if (vca_ok) begin state <= ACTIVE; ovc <= grant_ovc; end
        default: if (sw_pop && front[FLIT_W-1]) state <= IDLE;
      endcase
    end
  end
endmodule

module vc_input_port #(
  parameter  int FLIT_W = 16,
  parameter  int NUM_VC = 4,
  parameter  int DEPTH  = 4,
  localparam int VCW    = $clog2(NUM_VC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [VCW-1:0]    in_vc,
  input  logic [FLIT_W-1:0] in_flit,
  output logic [NUM_VC-1:0] credit_out,
  output logic              route_req,
  output logic [VCW-1:0]    route_vc,
  output logic [3:0]        route_info,
  input  logic              route_done,
  input  logic [2:0]        route_dir,
  output logic              vc_req,
  output logic [VCW-1:0]    vc_req_vc,
  output logic [2:0]        vc_req_dir,
  input  logic              vc_grant,
  input  logic [VCW-1:0]    vc_grant_ovc,
  output logic              sw_req,
  output logic [2:0]        sw_req_dir,
  input  logic              sw_grant,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit,
  output logic [VCW-1:0]    out_ovc,
  output logic              err_overflow
);
  logic [NUM_VC-1:0][FLIT_W-1:0] lane_front;
  logic [NUM_VC-1:0][2:0]        lane_dir;
  logic [NUM_VC-1:0][VCW-1:0]    lane_ovc;
  logic [NUM_VC-1:0] lane_full, pop_v, route_elig, vca_wait, active_rdy;

  logic [VCW-1:0] rr_route, rr_vca, rr_sw, sw_sel_q;
  logic [VCW-1:0] route_win, vca_win, sw_pick, sw_sel;
  logic           route_win_v, vca_win_v, sw_hold, sw_fire;

  // First requester at or after ptr, wrapping; MSB flags a hit.
  function automatic logic [VCW:0] rr_pick(input logic [NUM_VC-1:0] req,
                                           input logic [VCW-1:0] ptr);
    logic [VCW-1:0] idx;
    rr_pick = '0;
    for (int i = NUM_VC-1; i >= 0; i--) begin
      idx = ptr + VCW'(i);
      if (req[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  always_comb begin
    {route_win_v, route_win} = rr_pick(route_elig, rr_route);
    {vca_win_v, vca_win}     = rr_pick(vca_wait, rr_vca);
    {sw_req, sw_pick}        = rr_pick(active_rdy, rr_sw);
  end

  // An ungranted switch request keeps its VC until the grant arrives.
  assign sw_sel     = sw_hold ? sw_sel_q : sw_pick;
  assign sw_fire    = sw_req && sw_grant;
  assign sw_req_dir = sw_req ? lane_dir[sw_sel] : 3'd0;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_lane
    vc_lane #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .VCW(VCW)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .wr         (in_valid && in_vc == VCW'(v) && (!lane_full[v] || pop_v[v])),
      .wr_data    (in_flit),
      .sw_pop     (sw_fire && sw_sel == VCW'(v)),
      .route_start(!route_req && route_win_v && route_win == VCW'(v)),
      .route_ok   (route_req && route_done && route_vc == VCW'(v)),
      .route_dir  (route_dir),
      .vca_ok     (vc_req && vc_grant && vc_req_vc == VCW'(v)),
      .grant_ovc  (vc_grant_ovc),
      .front      (lane_front[v]),
      .full       (lane_full[v]),
      .pop        (pop_v[v]),
      .route_elig (route_elig[v]),
      .vca_wait   (vca_wait[v]),
      .active_rdy (active_rdy[v]),
      .dir        (lane_dir[v]),
      .ovc        (lane_ovc[v])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_out   <= '0;
      route_req    <= 1'b0;
      route_vc     <= '0;
      route_info   <= '0;
      rr_route     <= '0;
      vc_req       <= 1'b0;
      vc_req_vc    <= '0;
      vc_req_dir   <= '0;
      rr_vca       <= '0;
      rr_sw        <= '0;
      sw_hold      <= 1'b0;
      sw_sel_q     <= '0;
      out_valid    <= 1'b0;
      out_flit     <= '0;
      out_ovc      <= '0;
      err_overflow <= 1'b0;
    end else begin
      credit_out   <= pop_v;
      err_overflow <= err_overflow | (in_valid & lane_full[in_vc] & ~pop_v[in_vc]);
      out_valid    <= sw_fire;
      sw_hold      <= sw_req && !sw_grant;
      sw_sel_q     <= sw_sel;
      if (sw_fire) begin
        out_flit <= lane_front[sw_sel];
        out_ovc  <= lane_ovc[sw_sel];
        rr_sw    <= sw_sel + VCW'(1);
      end
      if (route_req) begin
        if (route_done) begin
          route_req <= 1'b0;
          rr_route  <= route_vc + VCW'(1);
        end
      end else if (route_win_v) begin
        route_req  <= 1'b1;
        route_vc   <= route_win;
        route_info <= lane_front[route_win][FLIT_W-3 -: 4];
      end
      if (vc_req) begin
        if (vc_grant) begin
          vc_req <= 1'b0;
          rr_vca <= vc_req_vc + VCW'(1);
        end
      end else if (vca_win_v) begin
        vc_req     <= 1'b1;
        vc_req_vc  <= vca_win;
        vc_req_dir <= lane_dir[vca_win];
      end
    end
  end
endmodule

// File: tb/tb_vc_input_port.sv
// Directed bench for vc_input_port: route/VC/switch handshakes, overflow, arbitration order, reset.
module tb_vc_input_port;
  logic        clk = 1'b0, rst;
  logic        in_valid;
  logic [1:0]  in_vc;
  logic [15:0] in_flit;
  logic [3:0]  credit_out;
  logic        route_req, route_done, vc_req, vc_grant, sw_req, sw_grant, out_valid, err_overflow;
  logic [1:0]  route_vc, vc_req_vc, vc_grant_ovc, out_ovc;
  logic [3:0]  route_info;
  logic [2:0]  route_dir, vc_req_dir, sw_req_dir;
  logic [15:0] out_flit;
  int tests = 0, fails = 0;

  vc_input_port #(.FLIT_W(16), .NUM_VC(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
    .credit_out(credit_out), .route_req(route_req), .route_vc(route_vc), .route_info(route_info),
    .route_done(route_done), .route_dir(route_dir), .vc_req(vc_req), .vc_req_vc(vc_req_vc),
    .vc_req_dir(vc_req_dir), .vc_grant(vc_grant), .vc_grant_ovc(vc_grant_ovc), .sw_req(sw_req),
    .sw_req_dir(sw_req_dir), .sw_grant(sw_grant), .out_valid(out_valid), .out_flit(out_flit),
    .out_ovc(out_ovc), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick; @(posedge clk); #1; endtask

  task automatic idle_inputs;
    in_valid = 0; in_vc = 0; in_flit = 0; route_done = 0; route_dir = 0;
    vc_grant = 0; vc_grant_ovc = 0; sw_grant = 0;
  endtask

  task automatic do_reset;
    idle_inputs(); rst = 0; tick(); tick(); rst = 1;
  endtask

  task automatic push(input logic [1:0] vc, input logic [15:0] f);
    in_valid = 1; in_vc = vc; in_flit = f; tick(); in_valid = 0;
  endtask

  // Head in, then walk it through route and VC allocation (no other VC contending).
  task automatic bring_active(input logic [1:0] vc, input logic [15:0] head,
                              input logic [2:0] dir, input logic [1:0] ovc);
    push(vc, head); tick();
    route_done = 1; route_dir = dir; tick(); route_done = 0; tick();
    vc_grant = 1; vc_grant_ovc = ovc; tick(); vc_grant = 0;
  endtask

  task automatic test_reset;
    idle_inputs(); rst = 0; tick();
    tests++; if ({route_req, vc_req, sw_req, out_valid, credit_out, err_overflow} !== 9'd0) begin
      fails++; $display("FAIL reset_ctrl got %b exp 0", {route_req, vc_req, sw_req, out_valid, credit_out, err_overflow}); end
    tests++; if ({route_vc, route_info, vc_req_vc, vc_req_dir, sw_req_dir, out_flit, out_ovc} !== 32'd0) begin
      fails++; $display("FAIL reset_data got %h exp 0", {route_vc, route_info, vc_req_vc, vc_req_dir, sw_req_dir, out_flit, out_ovc}); end
    rst = 1;
  endtask

  task automatic test_spurious;
    do_reset();
    route_done = 1; vc_grant = 1; sw_grant = 1; tick(); idle_inputs(); tick();
    tests++; if ({route_req, vc_req, sw_req, out_valid, credit_out} !== 8'd0) begin
      fails++; $display("FAIL spurious got %b exp 0", {route_req, vc_req, sw_req, out_valid, credit_out}); end
  endtask

  task automatic test_single;
    do_reset();
    push(2'd2, 16'hC5A3); tick();
    tests++; if ({route_req, route_vc, route_info} !== {1'b1, 2'd2, 4'h1}) begin
      fails++; $display("FAIL single_route got %b exp 1_10_0001", {route_req, route_vc, route_info}); end
    route_done = 1; route_dir = 3'd3; tick(); route_done = 0;
    tests++; if (route_req !== 1'b0) begin fails++; $display("FAIL single_route_drop got %b exp 0", route_req); end
    tick();
    tests++; if ({vc_req, vc_req_vc, vc_req_dir} !== {1'b1, 2'd2, 3'd3}) begin
      fails++; $display("FAIL single_vca got %b exp 1_10_011", {vc_req, vc_req_vc, vc_req_dir}); end
    vc_grant = 1; vc_grant_ovc = 2'd1; tick(); vc_grant = 0;
    tests++; if ({vc_req, sw_req, sw_req_dir, out_valid} !== {1'b0, 1'b1, 3'd3, 1'b0}) begin
      fails++; $display("FAIL single_swreq got %b exp 0_1_011_0", {vc_req, sw_req, sw_req_dir, out_valid}); end
    sw_grant = 1; tick(); sw_grant = 0;
    tests++; if ({out_valid, out_flit, out_ovc, credit_out} !== {1'b1, 16'hC5A3, 2'd1, 4'b0100}) begin
      fails++; $display("FAIL single_out got %h exp 1_c5a3_1_4", {out_valid, out_flit, out_ovc, credit_out}); end
    tests++; if (dut.g_lane[2].u_lane.state !== 2'd0) begin
      fails++; $display("FAIL single_idle got %0d exp 0", dut.g_lane[2].u_lane.state); end
    tick();
    tests++; if ({out_valid, credit_out, sw_req} !== 6'd0) begin
      fails++; $display("FAIL single_after got %b exp 0", {out_valid, credit_out, sw_req}); end
  endtask

  task automatic test_packet;
    logic [15:0] pk [4];
    pk = '{16'h4400, 16'h0011, 16'h0022, 16'h8033};
    do_reset();
    for (int i = 0; i < 4; i++) push(2'd0, pk[i]);
    route_done = 1; route_dir = 3'd2; tick(); route_done = 0; tick();
    vc_grant = 1; vc_grant_ovc = 2'd3; tick(); vc_grant = 0;
    sw_grant = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if ({out_valid, out_flit, out_ovc} !== {1'b1, pk[i], 2'd3}) begin
        fails++; $display("FAIL packet_flit%0d got %h exp 1_%h_3", i, {out_valid, out_flit, out_ovc}, pk[i]); end
    end
    sw_grant = 0;
    tests++; if (dut.g_lane[0].u_lane.state !== 2'd0) begin
      fails++; $display("FAIL packet_idle got %0d exp 0", dut.g_lane[0].u_lane.state); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL packet_stop got %b exp 0", out_valid); end
  endtask

  task automatic test_overflow;
    do_reset();
    for (int i = 0; i < 4; i++) push(2'd1, 16'h4000 | 16'(i));
    tests++; if ({err_overflow, dut.g_lane[1].u_lane.count} !== {1'b0, 3'd4}) begin
      fails++; $display("FAIL ovf_fill got %b exp 0_100", {err_overflow, dut.g_lane[1].u_lane.count}); end
    push(2'd1, 16'h4005);
    tests++; if ({err_overflow, dut.g_lane[1].u_lane.count} !== {1'b1, 3'd4}) begin
      fails++; $display("FAIL ovf_drop got %b exp 1_100", {err_overflow, dut.g_lane[1].u_lane.count}); end
    tick();
    tests++; if (err_overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b exp 1", err_overflow); end
  endtask

  task automatic test_rr_route;
    do_reset();
    for (int v = 0; v < 4; v++) push(2'(v), 16'h4000 | (16'(v + 5) << 10));
    for (int v = 0; v < 4; v++) begin
      tests++; if ({route_req, route_vc, route_info} !== {1'b1, 2'(v), 4'(v + 5)}) begin
        fails++; $display("FAIL rr_route%0d got %b exp 1_%b_%b", v, {route_req, route_vc, route_info}, 2'(v), 4'(v + 5)); end
      tick();
      tests++; if ({route_req, route_vc, route_info} !== {1'b1, 2'(v), 4'(v + 5)}) begin
        fails++; $display("FAIL rr_hold%0d got %b exp 1_%b_%b", v, {route_req, route_vc, route_info}, 2'(v), 4'(v + 5)); end
      route_done = 1; route_dir = 3'(v); tick(); route_done = 0;
      tests++; if (route_req !== 1'b0) begin fails++; $display("FAIL rr_drop%0d got %b exp 0", v, route_req); end
      tick();
    end
  endtask

  task automatic test_full_wr_pop;
    do_reset();
    bring_active(2'd3, 16'h4000, 3'd1, 2'd2);
    push(2'd3, 16'h0011); push(2'd3, 16'h0022); push(2'd3, 16'h0033);
    tests++; if (dut.g_lane[3].u_lane.count !== 3'd4) begin
      fails++; $display("FAIL full_count got %0d exp 4", dut.g_lane[3].u_lane.count); end
    in_valid = 1; in_vc = 2'd3; in_flit = 16'h0044; sw_grant = 1; tick(); in_valid = 0; sw_grant = 0;
    tests++; if ({dut.g_lane[3].u_lane.count, err_overflow} !== {3'd4, 1'b0}) begin
      fails++; $display("FAIL full_wrpop got %b exp 100_0", {dut.g_lane[3].u_lane.count, err_overflow}); end
    tests++; if ({out_valid, out_flit, out_ovc, credit_out} !== {1'b1, 16'h4000, 2'd2, 4'b1000}) begin
      fails++; $display("FAIL full_out got %h exp 1_4000_2_8", {out_valid, out_flit, out_ovc, credit_out}); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    bring_active(2'd0, 16'h4400, 3'd2, 2'd1);
    push(2'd0, 16'h0011); push(2'd0, 16'h0022);
    sw_grant = 1; tick(); sw_grant = 0;
    #2 rst = 0; #1;
    tests++; if ({route_req, vc_req, sw_req, out_valid, credit_out, err_overflow, out_flit} !== 25'd0) begin
      fails++; $display("FAIL rstmid_out got %h exp 0", {route_req, vc_req, sw_req, out_valid, credit_out, err_overflow, out_flit}); end
    tests++; if ({dut.g_lane[0].u_lane.count, dut.g_lane[1].u_lane.count, dut.g_lane[2].u_lane.count,
                  dut.g_lane[3].u_lane.count, dut.g_lane[0].u_lane.state} !== 14'd0) begin
      fails++; $display("FAIL rstmid_fifo got %0d exp 0", dut.g_lane[0].u_lane.count); end
    tick(); rst = 1; tick();
    tests++; if ({credit_out, out_valid} !== 5'd0) begin
      fails++; $display("FAIL rstmid_credit got %b exp 0", {credit_out, out_valid}); end
    push(2'd1, 16'hC800); tick();
    tests++; if ({route_req, route_vc, route_info} !== {1'b1, 2'd1, 4'h2}) begin
      fails++; $display("FAIL rstmid_route got %b exp 1_01_0010", {route_req, route_vc, route_info}); end
  endtask

  initial begin
    idle_inputs(); rst = 0;
    test_reset();
    test_spurious();
    test_single();
    test_packet();
    test_overflow();
    test_rr_route();
    test_full_wr_pop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
